// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: opcodes, register names, instruction
// field positions, fetch state encodings and the bubble word.
package instruction_fetch_pkg;

    localparam logic [3:0] NOP = 4'd0;
    localparam logic [3:0] LED = 4'd1;
    localparam logic [3:0] BLE = 4'd2;
    localparam logic [3:0] STO = 4'd3;
    localparam logic [3:0] ADD = 4'd4;
    localparam logic [3:0] JMP = 4'd5;
    localparam logic [3:0] SUB = 4'd6;

    localparam logic [7:0] R0 = 8'd0;
    localparam logic [7:0] R1 = 8'd1;
    localparam logic [7:0] R2 = 8'd2;
    localparam logic [7:0] R3 = 8'd3;
    localparam logic [7:0] R4 = 8'd4;
    localparam logic [7:0] R5 = 8'd5;
    localparam logic [7:0] R6 = 8'd6;
    localparam logic [7:0] R7 = 8'd7;

    localparam int OPCODE_MSB = 27;
    localparam int OPCODE_LSB = 24;
    localparam int DEST_MSB   = 23;
    localparam int DEST_LSB   = 16;
    localparam int SRCA_MSB   = 15;
    localparam int SRCA_LSB   = 8;
    localparam int SRCB_MSB   = 7;
    localparam int SRCB_LSB   = 0;

    localparam logic [27:0] BUBBLE = {NOP, 24'd0};

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_RUN   = 2'd1,
        FS_STALL = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JUMP   = 2'd3
    } pc_sel_e;

    function automatic logic [3:0] opcode_of(input logic [27:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    // Branch/jump targets are 8-bit fields, zero-extended to the PC width.
    function automatic logic [15:0] target_of(input logic [27:0] instr);
        return {8'd0, instr[DEST_MSB:DEST_LSB]};
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// Combinational next-PC selection for the fetch stage: hold, increment,
// execute-stage branch redirect or early JMP redirect.
module fetch_pc_next
    import instruction_fetch_pkg::*;
(
    input  fetch_state_e  state,
    input  logic [15:0]   pc,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [15:0]   branch_target,
    input  logic          early_jmp,
    input  logic [15:0]   jmp_target,
    output pc_sel_e       pc_sel,
    output logic [15:0]   next_pc
);

    // Priority: execute redirect, then stall, then early JMP, then sequential.
    always_comb begin
        pc_sel = PC_HOLD;
        case (state)
            FS_RUN, FS_STALL: begin
                if (branch_taken) begin
                    pc_sel = PC_BRANCH;
                end else if (stall) begin
                    pc_sel = PC_HOLD;
                end else if (early_jmp) begin
                    pc_sel = PC_JUMP;
                end else begin
                    pc_sel = PC_INC;
                end
            end
            default: pc_sel = PC_HOLD;
        endcase
    end

    // PC arithmetic wraps modulo 2^16.
    always_comb begin
        next_pc = pc;
        case (pc_sel)
            PC_HOLD:   next_pc = pc;
            PC_INC:    next_pc = pc + 16'd1;
            PC_BRANCH: next_pc = branch_target;
            PC_JUMP:   next_pc = jmp_target;
            default:   next_pc = pc;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Program-counter sequencer feeding the fetch/decode pipeline register.
// Optional feature: FETCH_EARLY_JMP_EN resolves JMP in fetch with one bubble.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'd0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iEnable,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchTarget,
    output logic [15:0] oAddress,
    input  logic [27:0] iInstruction,
    output logic [27:0] oInstruction,
    output logic [15:0] oPC,
    output logic        oValid
);

    fetch_state_e state;
    logic [15:0]  pc;
    logic [15:0]  next_pc;
    logic [15:0]  jmp_target;
    logic         early_jmp;
    pc_sel_e      pc_sel;

    assign oAddress   = pc;
    assign jmp_target = target_of(iInstruction);

`ifdef FETCH_EARLY_JMP_EN
    assign early_jmp = (opcode_of(iInstruction) == JMP);
`else
    assign early_jmp = 1'b0;
`endif

    fetch_pc_next u_pc_next (
        .state         (state),
        .pc            (pc),
        .stall         (iStall),
        .branch_taken  (iBranchTaken),
        .branch_target (iBranchTarget),
        .early_jmp     (early_jmp),
        .jmp_target    (jmp_target),
        .pc_sel        (pc_sel),
        .next_pc       (next_pc)
    );

    // State, PC and pipeline register; a redirect always replaces the
    // younger wrong-path instruction with a bubble.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= FS_IDLE;
            pc           <= RESET_PC;
            oInstruction <= BUBBLE;
            oPC          <= 16'd0;
            oValid       <= 1'b0;
        end else begin
            pc <= next_pc;
            case (state)
                FS_IDLE: begin
                    if (iEnable) begin
                        state <= FS_RUN;
                    end else begin
                        state <= FS_IDLE;
                    end
                end
                FS_RUN, FS_STALL: begin
                    case (pc_sel)
                        PC_BRANCH, PC_JUMP: begin
                            oInstruction <= BUBBLE;
                            oValid       <= 1'b0;
                            state        <= FS_RUN;
                        end
                        PC_INC: begin
                            oInstruction <= iInstruction;
                            oPC          <= pc;
                            oValid       <= 1'b1;
                            state        <= FS_RUN;
                        end
                        PC_HOLD: begin
                            state <= FS_STALL;
                        end
                        default: begin
                            state <= FS_IDLE;
                        end
                    endcase
                end
                default: begin
                    state <= FS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a combinational
// model of the delay-loop program ROM.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        stall;
    logic        br;
    logic [15:0] br_tgt;
    logic [15:0] addr;
    logic [27:0] rom_data;
    logic [27:0] instr;
    logic [15:0] pc;
    logic        valid;

    logic        w_en;
    logic [15:0] w_addr;
    logic [27:0] w_rom_data;
    logic [27:0] w_instr;
    logic [15:0] w_pc;
    logic        w_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [27:0] rom_word(input logic [15:0] a);
        case (a)
            16'd0:   return {NOP, 24'd4000};
            16'd1:   return {STO, R7, 16'd1};
            16'd2:   return {STO, R3, 16'd1};
            16'd3:   return {STO, R4, 16'd1000};
            16'd4:   return {STO, R5, 16'd0};
            16'd5:   return {LED, 8'd0, R7, 8'd0};
            16'd6:   return {STO, R1, 16'd0};
            16'd7:   return {STO, R2, 16'd5000};
            16'd8:   return {ADD, R1, R1, R3};
            16'd9:   return {BLE, 8'd8, R1, R2};
            16'd10:  return {ADD, R5, R5, R3};
            16'd11:  return {BLE, 8'd6, R5, R4};
            16'd12:  return {NOP, 24'd0};
            16'd13:  return {ADD, R7, R7, R3};
            16'd14:  return {JMP, 8'd2, 16'd0};
            default: return {LED, 24'd0};
        endcase
    endfunction

    assign rom_data   = rom_word(addr);
    assign w_rom_data = rom_word(w_addr);

    instruction_fetch #(.RESET_PC(16'd0)) u_dut (
        .Clock         (clk),
        .Reset         (rst),
        .iEnable       (en),
        .iStall        (stall),
        .iBranchTaken  (br),
        .iBranchTarget (br_tgt),
        .oAddress      (addr),
        .iInstruction  (rom_data),
        .oInstruction  (instr),
        .oPC           (pc),
        .oValid        (valid)
    );

    instruction_fetch #(.RESET_PC(16'hFFFF)) u_wrap (
        .Clock         (clk),
        .Reset         (rst),
        .iEnable       (w_en),
        .iStall        (1'b0),
        .iBranchTaken  (1'b0),
        .iBranchTarget (16'd0),
        .oAddress      (w_addr),
        .iInstruction  (w_rom_data),
        .oInstruction  (w_instr),
        .oPC           (w_pc),
        .oValid        (w_valid)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input string tag, input logic [15:0] exp_pc);
        check({tag, " valid"}, {31'd0, valid}, 32'd1);
        check({tag, " pc"}, {16'd0, pc}, {16'd0, exp_pc});
        check({tag, " instr"}, {4'd0, instr}, {4'd0, rom_word(exp_pc)});
    endtask

    task automatic expect_bubble(input string tag, input logic [15:0] exp_addr);
        check({tag, " valid"}, {31'd0, valid}, 32'd0);
        check({tag, " instr"}, {4'd0, instr}, {4'd0, BUBBLE});
        check({tag, " addr"}, {16'd0, addr}, {16'd0, exp_addr});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; stall = 1'b0; br = 1'b0; br_tgt = 16'd0; w_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset addr", {16'd0, addr}, 32'd0);
        check("reset instr", {4'd0, instr}, {4'd0, BUBBLE});
        check("reset pc", {16'd0, pc}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        rst = 1'b0;

        step();
        check("idle valid", {31'd0, valid}, 32'd0);
        check("idle addr", {16'd0, addr}, 32'd0);

        en = 1'b1;
        step();
        en = 1'b0;
        check("enable edge1 valid", {31'd0, valid}, 32'd0);
        step();
        expect_fetch("first fetch", 16'd0);
        check("first fetch addr", {16'd0, addr}, 32'd1);

        for (int k = 1; k <= 5; k++) begin
            step();
            expect_fetch($sformatf("seq %0d", k), k[15:0]);
        end

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_fetch($sformatf("stall %0d", k), 16'd5);
            check("stall addr", {16'd0, addr}, 32'd6);
        end
        stall = 1'b0;
        step();
        expect_fetch("after stall", 16'd6);

        for (int k = 7; k <= 9; k++) begin
            step();
            expect_fetch($sformatf("seq %0d", k), k[15:0]);
        end

        br = 1'b1; br_tgt = 16'd8;
        step();
        br = 1'b0;
        expect_bubble("branch bubble", 16'd8);
        step();
        expect_fetch("branch target", 16'd8);
        check("branch target word", {4'd0, instr}, {4'd0, ADD, R1, R1, R3});

        stall = 1'b1; br = 1'b1; br_tgt = 16'd2;
        step();
        stall = 1'b0; br = 1'b0;
        expect_bubble("stall+branch bubble", 16'd2);
        step();
        expect_fetch("stall+branch target", 16'd2);

        stall = 1'b1;
        step();
        expect_fetch("stall hold", 16'd2);
        br = 1'b1; br_tgt = 16'd12;
        step();
        stall = 1'b0; br = 1'b0;
        expect_bubble("branch from stall", 16'd12);
        step();
        expect_fetch("branch from stall target", 16'd12);
        step();
        expect_fetch("seq 13", 16'd13);
        check("jmp fetch addr", {16'd0, addr}, 32'd14);

        step();
`ifdef FETCH_EARLY_JMP_EN
        expect_bubble("early jmp bubble", 16'd2);
        step();
        expect_fetch("early jmp target", 16'd2);
`else
        expect_fetch("jmp forwarded", 16'd14);
        check("jmp word", {4'd0, instr}, {4'd0, JMP, 8'd2, 16'd0});
        check("jmp next addr", {16'd0, addr}, 32'd15);
`endif

        #2;
        rst = 1'b1;
        #1;
        check("async reset valid", {31'd0, valid}, 32'd0);
        check("async reset addr", {16'd0, addr}, 32'd0);
        check("async reset instr", {4'd0, instr}, {4'd0, BUBBLE});
        check("async reset wrap addr", {16'd0, w_addr}, 32'h0000FFFF);
        step();
        rst = 1'b0;

        w_en = 1'b1;
        step();
        w_en = 1'b0;
        check("wrap edge1 addr", {16'd0, w_addr}, 32'h0000FFFF);
        check("wrap edge1 valid", {31'd0, w_valid}, 32'd0);
        check("main stays idle", {31'd0, valid}, 32'd0);
        step();
        check("wrap valid", {31'd0, w_valid}, 32'd1);
        check("wrap pc", {16'd0, w_pc}, 32'h0000FFFF);
        check("wrap instr", {4'd0, w_instr}, {4'd0, LED, 24'd0});
        check("wrap addr", {16'd0, w_addr}, 32'd0);
        step();
        check("wrap pc0", {16'd0, w_pc}, 32'd0);
        check("wrap instr0", {4'd0, w_instr}, {4'd0, NOP, 24'd4000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter sequencer that reads the combinational instruction ROM, the reader side of the ROM's address/instruction interface. It drives the 16-bit ROM address, captures the returned 28-bit instruction into a fetch/decode pipeline register with a valid flag, and honours stall and branch-redirect requests from the execute stage. It sits between the ROM and the MiniAlu decode/execute logic.

## Interface
- RESET_PC, 16'd0: PC value loaded on reset.
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- iEnable  input  1  leaves IDLE on first cycle high; ignored after that.
- iStall  input  1  decode/execute cannot accept; hold PC and pipeline register.
- iBranchTaken  input  1  execute resolved a taken BLE/JMP this cycle.
- iBranchTarget  input  16  redirect address; execute zero-extends the 8-bit instruction field.
- oAddress  output  16  ROM address, equals the PC register.
- iInstruction  input  28  ROM data for oAddress, same cycle, combinational.
- oInstruction  output  28  registered instruction to decode.
- oPC  output  16  address oInstruction was fetched from.
- oValid  output  1  oInstruction is a real instruction, not a bubble.

## Operation
- Instruction fields: [27:24] opcode, [23:16] destination/branch target, [15:8] source A, [7:0] source B; [15:0] immediate for STO.
- Bubble = {`NOP, 24'd0} with oValid=0.
- States: IDLE, RUN, STALL.
- IDLE: oAddress = RESET_PC, oValid=0, nothing captured. iEnable=1 -> RUN next cycle.
- RUN, per cycle, highest priority first:
  - iBranchTaken=1: PC <= iBranchTarget; register <= bubble; stay RUN. Applies even if iStall=1, because the younger instruction is wrong-path.
  - iStall=1: PC, oInstruction, oPC, oValid held; -> STALL.
  - otherwise: oInstruction <= iInstruction, oPC <= PC, oValid <= 1, PC <= PC+1.
- STALL: same priority list. iBranchTaken wins (-> RUN with redirect). iStall=0 -> RUN with the capture/increment of the RUN otherwise-case in that same cycle, with no lost cycle.
- PC arithmetic: 16-bit modulo. 16'hFFFF+1 = 16'h0000, no flag.
- Unknown opcodes and the ROM default word are passed through untouched. Decode owns legality.
- Reset asserted mid-operation: all state is cleared immediately (asynchronous), and the block returns to IDLE. An in-flight instruction is discarded.

## Timing
- Reset values: oAddress=RESET_PC, oInstruction={`NOP,24'd0}, oPC=16'd0, oValid=0, state=IDLE.
- Fetch latency: 1 cycle from oAddress to oInstruction/oValid.
- Branch penalty: 1 bubble cycle after iBranchTaken. The instruction at iBranchTarget appears 2 edges after the iBranchTaken edge.
- Stall: outputs held every cycle iStall=1. The first new capture occurs on the edge where iStall=0.
- IDLE->RUN: the first valid instruction (RESET_PC) appears 2 edges after iEnable is sampled high.

## Configuration
- FETCH_EARLY_JMP_EN defined:
  - In RUN/STALL, with no iBranchTaken and no iStall, an iInstruction with opcode `JMP redirects PC <= {8'b0, iInstruction[23:16]}.
  - The JMP itself is not forwarded; the register gets a bubble. The cost is 1 bubble, and no execute round-trip occurs.
  - iBranchTaken still has priority over an early JMP in the same cycle.
- FETCH_EARLY_JMP_EN undefined: JMP is forwarded like any instruction, and execute must assert iBranchTaken.

## Structure
- Opcode and register defines (`NOP, `JMP, `BLE, `LED, `STO, `ADD, `SUB, `R0..`R7) come from the shared Defintions.v header.
- Add to that header: field slice positions, the state encodings (FS_IDLE, FS_RUN, FS_STALL), and the bubble word.
- One sub-module, fetch_pc_next: combinational next-PC mux (hold / +1 / branch / early JMP).
- The state register and the pipeline register stay in instruction_fetch.

## Test plan
- Reset, then iEnable for 1 cycle, with the ROM loaded with the standard delay-loop program:
  - oValid rises 2 edges later with oPC=0 and oInstruction={`NOP,24'd4000}.
  - oPC then steps 1, 2, 3, ...
- Sequential run to address 9, then iBranchTaken=1 with iBranchTarget=16'd8:
  - one bubble (oValid=0), then oPC=8 with the ADD R1,R1,R3 word.
- iStall high for 3 cycles while oPC=5:
  - oInstruction/oPC/oValid are frozen for 3 cycles.
  - oPC=6 appears on the first edge after iStall falls.
- iStall=1 and iBranchTaken=1 together, target 16'd2:
  - the redirect wins, a bubble is emitted, and oPC=2 follows.
- With FETCH_EARLY_JMP_EN, fetch address 14 ({`JMP, 8'd2, 16'b0}):
  - a bubble is emitted, the next oPC=2, and iBranchTaken is never needed.
  - Without the macro, the JMP word appears at oPC=14.
- Preload PC to 16'hFFFF via RESET_PC:
  - the next oAddress is 16'h0000.
  - Reset asserted mid-run forces oValid=0 and oAddress=RESET_PC immediately, with no clock edge needed.
